// File: rtl/pio_pkg.sv
// Shared constants and types for the edge-capturing input PIO.
package pio_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 2;

    localparam logic [ADDR_W-1:0] ADDR_DATA    = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_RSVD    = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

    typedef enum logic {
        IRQ_LEVEL = 1'b0,
        IRQ_EDGE  = 1'b1
    } irq_mode_e;

endpackage

// File: rtl/pio_sync.sv
// Multi-flop synchroniser for an asynchronous input bus.
//   clk, reset_n : clock and async active-low reset
//   d            : asynchronous input
//   q            : synchronised output (d itself when STAGES == 0)
module pio_sync #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign q = d;
        end else begin : g_chain
            logic [WIDTH-1:0] stage_q [STAGES];

            // Shift chain; every stage clears on reset.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < int'(STAGES); i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= d;
                    for (int i = 1; i < int'(STAGES); i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q = stage_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO with per-bit edge capture and maskable interrupt.
//   clk, reset_n          : clock, async active-low reset
//   address, chipselect,
//   write_n, writedata    : Avalon-MM slave (0 data, 1 reserved, 2 irqmask, 3 edgecapture)
//   in_port               : external asynchronous input
//   readdata              : registered read data, 1-cycle latency
//   irq                   : registered interrupt request
module pio_in_edge_irq
    import pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter edge_type_e  EDGE_TYPE   = EDGE_RISE,
    parameter irq_mode_e   IRQ_MODE    = IRQ_EDGE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [DATA_W-1:0] readdata,
    output logic              irq
);

    localparam int unsigned ARM_W   = 3;
    localparam int unsigned ARM_MAX = SYNC_STAGES + 1;

    logic [WIDTH-1:0]  s;
    logic [WIDTH-1:0]  prev;
    logic [WIDTH-1:0]  irqmask;
    logic [WIDTH-1:0]  edgecapture;
    logic [ARM_W-1:0]  arm_cnt;
    logic              armed_c;
    logic              wr_c;
    logic [WIDTH-1:0]  clr_c;
    logic [WIDTH-1:0]  edge_c;
    logic [DATA_W-1:0] rd_c;
    logic              irq_c;

    pio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (s)
    );

    // Upper write-data bits have no storage behind them.
    generate
        if (WIDTH < DATA_W) begin : g_wdata_unused
            logic unused_wdata;
            assign unused_wdata = ^writedata[DATA_W-1:WIDTH];
        end
    endgenerate

    assign wr_c    = chipselect & ~write_n;
    assign armed_c = (arm_cnt == ARM_W'(ARM_MAX));
    assign clr_c   = (wr_c && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    // Edge vector; held off until the synchroniser and prev have been flushed.
    always_comb begin
        edge_c = '0;
        case (EDGE_TYPE)
            EDGE_RISE: edge_c = s & ~prev;
            EDGE_FALL: edge_c = ~s & prev;
            default:   edge_c = s ^ prev;
        endcase
        if (!armed_c) begin
            edge_c = '0;
        end
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        rd_c = '0;
        case (address)
            ADDR_DATA:    rd_c[WIDTH-1:0] = s;
            ADDR_IRQMASK: rd_c[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: rd_c[WIDTH-1:0] = edgecapture;
            default:      rd_c = '0;
        endcase
    end

    assign irq_c = (IRQ_MODE == IRQ_LEVEL) ? |(s & irqmask) : |(edgecapture & irqmask);

    // State and registered outputs; a new edge overrides a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev        <= '0;
            arm_cnt     <= '0;
            irqmask     <= '0;
            edgecapture <= '0;
            readdata    <= '0;
            irq         <= 1'b0;
        end else begin
            prev <= s;
            if (!armed_c) begin
                arm_cnt <= arm_cnt + ARM_W'(1);
            end
            if (wr_c && address == ADDR_IRQMASK) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            edgecapture <= (edgecapture & ~clr_c) | edge_c;
            readdata    <= rd_c;
            irq         <= irq_c;
        end
    end

endmodule

// File: doc/pio_in_edge_irq.md
# pio_in_edge_irq

Parametrised Avalon-MM input PIO for the SistemaEmbarcadoRansac Nios system, replacing the fixed 1-bit input port. It synchronises a WIDTH-bit external input, exposes it as a readable data register, and latches per-bit edges in a write-1-to-clear capture register. It raises a maskable interrupt to the Nios IRQ line.

## Interface
- WIDTH, 8: input bits, 1..32; readdata bits above WIDTH read 0.
- SYNC_STAGES, 2: synchroniser depth, 0..3; 0 means in_port is used directly.
- EDGE_TYPE, 0: 0 rising, 1 falling, 2 any edge.
- IRQ_MODE, 1: 0 level (data & mask), 1 edge (capture & mask).
- clk  in  1  system clock; one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register select: 0 data, 1 reserved, 2 irqmask, 3 edgecapture.
- chipselect  in  1  slave select; qualifies writes only.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above WIDTH ignored.
- in_port  in  WIDTH  external input, asynchronous to clk.
- readdata  out  32  registered read data.
- irq  out  1  registered interrupt request, active-high.

## Operation
- Synchroniser: s = in_port after SYNC_STAGES flops, all reset to 0.
- prev <= s every cycle; reset 0.
- Arm counter: counts SYNC_STAGES+1 cycles after reset release; edge detection disabled until it saturates, so inputs high at reset release produce no spurious edge.
- Edge vector e: rising s & ~prev; falling ~s & prev; any s ^ prev; forced 0 while unarmed.
- edgecapture[i]: set when e[i]=1; cleared by write to address 3 with writedata[i]=1; simultaneous set and clear -> stays 1 (set wins).
- irqmask: read/write at address 2, WIDTH bits.
- Address 1: reads 0, writes ignored. Address 0: writes ignored.
- Write = chipselect & ~write_n; no wait states.
- readdata <= zero-extended mux(address): data s, 0, irqmask, edgecapture; updated every cycle independent of chipselect.
- irq <= |(s & irqmask) in level mode, |(edgecapture & irqmask) in edge mode.

## Timing
- Reset values: readdata 0, irq 0, irqmask 0, edgecapture 0, sync flops 0, prev 0, arm counter 0.
- Read latency 1 cycle: address at edge k -> readdata valid after edge k.
- in_port to s: SYNC_STAGES cycles. s to data visible on readdata: +1 cycle.
- Edge at s (s != prev): edgecapture bit set at the next clock edge. irq asserts on the following edge.
- Total in_port -> irq in edge mode: SYNC_STAGES+2 cycles.
- Clear write at edge k: bit reads 0 in the read issued at k+1. irq deasserts after edge k+1 if no other masked bit is set.
- Mask write at edge k takes effect on irq at edge k+1.
- Reset mid-operation: all state cleared asynchronously; pending captures are lost; arm sequence restarts.

## Structure
- Package pio_pkg: address constants ADDR_DATA, ADDR_IRQMASK, ADDR_EDGECAP; edge_type_e enum (EDGE_RISE, EDGE_FALL, EDGE_ANY); irq_mode_e enum.
- Sub-module pio_sync: WIDTH by SYNC_STAGES flop chain with async active-low reset and a pass-through for 0 stages.
- Edge detect, capture, mask, read mux and irq stay in the top level.

## Test plan
- Reset then data read: WIDTH=8, SYNC_STAGES=2, in_port=8'hA5 -> read addr 0 returns 32'h000000A5 and never returns a stale value once in_port has been stable for 3 cycles.
- Spurious edge suppression: in_port=8'hFF during reset and release -> edgecapture reads 0 and irq stays 0.
- Rising capture with irq: mask 8'h01, in_port bit0 0->1 at cycle t -> edgecapture=8'h01 at t+3 and irq=1 at t+4. Write 32'h1 to addr 3 -> capture 0 and irq 0 one cycle later.
- Set wins: bit2 edge coincides with a clear write of 32'h4 -> edgecapture bit2 remains 1.
- EDGE_TYPE=2, IRQ_MODE=0: pulse bit3 high, mask 8'h08 -> capture holds 8'h08 after the pulse, while irq follows s bit3 (level) delayed 1 cycle.
- Async reset asserted mid-pulse with capture=8'h0F -> readdata, irq, irqmask and edgecapture are all 0 immediately, without waiting for a clock edge.
